// File: rtl/sync_fifo_prog_if.sv
// Producer/consumer bundle for sync_fifo_prog: request side in, data and status out.
interface sync_fifo_prog_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_W      = 4
);
    logic                  flush;
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output flush, data_in, wr_en, rd_en,
        input  data_out, count, full, empty, almostfull, almostempty,
               wr_ack, overflow, underflow
    );

    modport slave (
        input  flush, data_in, wr_en, rd_en,
        output data_out, count, full, empty, almostfull, almostempty,
               wr_ack, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO, any depth 2..1024, with occupancy count, threshold flags and flush.
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module sync_fifo_prog #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1,
    parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input logic            clk,
    input logic            rst,
    sync_fifo_prog_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 1024 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > FIFO_DEPTH)
    begin : g_param_err
        $fatal(1, "sync_fifo_prog: illegal FIFO_DEPTH/AF_LEVEL/AE_LEVEL combination");
    end

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  full, empty;
    logic                  rd_acc, wr_acc;
    logic                  wr_ack_q, overflow_q, underflow_q;

    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign rd_acc = bus.rd_en && !empty;
    // A full FIFO still takes a write when the same cycle pops a word.
    assign wr_acc = bus.wr_en && (!full || rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            count_q     <= count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            wr_ack_q    <= wr_acc;
            overflow_q  <= bus.wr_en && !wr_acc;
            underflow_q <= bus.rd_en && !rd_acc;
        end
    end

    // Storage has no reset; contents survive rst and flush.
    always_ff @(posedge clk) begin
        if (!rst && !bus.flush && wr_acc)
            mem[wr_ptr] <= bus.data_in;
    end

`ifdef FIFO_FWFT_EN
    assign bus.data_out = mem[rd_ptr];
`else
    logic [FIFO_WIDTH-1:0] dout_q;

    // Flush deliberately leaves the last read word on data_out.
    always_ff @(posedge clk) begin
        if (rst)
            dout_q <= '0;
        else if (!bus.flush && rd_acc)
            dout_q <= mem[rd_ptr];
    end

    assign bus.data_out = dout_q;
`endif

    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.empty       = empty;
    assign bus.almostfull  = (count_q >= CNT_W'(AF_LEVEL)) && !full;
    assign bus.almostempty = (count_q <= CNT_W'(AE_LEVEL)) && !empty;
    assign bus.wr_ack      = wr_ack_q;
    assign bus.overflow    = overflow_q;
    assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: depth-8 and depth-6 instances driven in lockstep,
// each checked every cycle against a list-based reference model.
module tb_sync_fifo_prog;
    logic        clk = 1'b0;
    logic        rst = 1'b0, flush = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [15:0] din = '0;
    int          n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.FIFO_WIDTH(16), .CNT_W(4)) ifa ();
    sync_fifo_prog_if #(.FIFO_WIDTH(16), .CNT_W(3)) ifb ();

    assign ifa.flush = flush;  assign ifb.flush = flush;
    assign ifa.wr_en = wr_en;  assign ifb.wr_en = wr_en;
    assign ifa.rd_en = rd_en;  assign ifb.rd_en = rd_en;
    assign ifa.data_in = din;  assign ifb.data_in = din;

    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    sync_fifo_prog #(.FIFO_WIDTH(16), .FIFO_DEPTH(6), .AF_LEVEL(4), .AE_LEVEL(2))
        dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic [6:0]  flg_w  [2];
    logic [3:0]  cnt_w  [2];
    logic [15:0] dout_w [2];
    assign flg_w[0]  = {ifa.empty, ifa.full, ifa.almostfull, ifa.almostempty,
                        ifa.wr_ack, ifa.overflow, ifa.underflow};
    assign flg_w[1]  = {ifb.empty, ifb.full, ifb.almostfull, ifb.almostempty,
                        ifb.wr_ack, ifb.overflow, ifb.underflow};
    assign cnt_w[0]  = ifa.count;
    assign cnt_w[1]  = {1'b0, ifb.count};
    assign dout_w[0] = ifa.data_out;
    assign dout_w[1] = ifb.data_out;

    // Reference model: an ordered list per FIFO, oldest word at index 0.
    int          dep [2] = '{8, 6};
    int          afl [2] = '{7, 4};
    int          ael [2] = '{1, 2};
    logic [15:0] mdat [2][8];
    int          mcnt [2] = '{0, 0};
    logic [15:0] mdout [2] = '{16'h0, 16'h0};
    bit          mack [2], mov [2], mun [2];
    string       fnm [7] = '{"empty", "full", "almostfull", "almostempty",
                             "wr_ack", "overflow", "underflow"};

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst || flush) begin
                mcnt[k] = 0;
                if (rst) mdout[k] = 16'h0;
                mack[k] = 0; mov[k] = 0; mun[k] = 0;
            end else begin
                bit ra, wa;
                ra = rd_en && mcnt[k] > 0;
                wa = wr_en && (mcnt[k] < dep[k] || ra);
                if (ra) begin
                    mdout[k] = mdat[k][0];
                    for (int i = 0; i < mcnt[k] - 1; i++) mdat[k][i] = mdat[k][i+1];
                    mcnt[k]--;
                end
                if (wa) begin
                    mdat[k][mcnt[k]] = din;
                    mcnt[k]++;
                end
                mack[k] = wa; mov[k] = wr_en && !wa; mun[k] = rd_en && !ra;
            end
        end
    endtask

    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            logic [6:0] ef;
            ef = {mcnt[k] == 0, mcnt[k] == dep[k],
                  mcnt[k] >= afl[k] && mcnt[k] < dep[k],
                  mcnt[k] <= ael[k] && mcnt[k] > 0,
                  mack[k], mov[k], mun[k]};
            for (int b = 0; b < 7; b++)
                cmp($sformatf("dut%0d_%s", k, fnm[b]), 32'(flg_w[k][6-b]), 32'(ef[6-b]));
            cmp($sformatf("dut%0d_count", k), 32'(cnt_w[k]), 32'(mcnt[k]));
`ifdef FIFO_FWFT_EN
            if (mcnt[k] > 0) cmp($sformatf("dut%0d_data_out", k), 32'(dout_w[k]), 32'(mdat[k][0]));
`else
            cmp($sformatf("dut%0d_data_out", k), 32'(dout_w[k]), 32'(mdout[k]));
`endif
        end
    endtask

    task automatic step(input bit r, input bit f, input bit w, input bit rd,
                        input logic [15:0] d);
        rst = r; flush = f; wr_en = w; rd_en = rd; din = d;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        bit          wr, rd;
        logic [15:0] din;
        int          cnt;
        bit          full, af, ack, ov, un;
        logic [15:0] dout;
    } vec_t;
    vec_t tbl [20];

    initial begin
        // Fill/drain on the depth-8 FIFO: 10 writes then 10 reads.
        for (int i = 0; i < 10; i++)
            tbl[i] = '{1'b1, 1'b0, 16'(i + 1), (i + 1 > 8) ? 8 : i + 1,
                       i + 1 >= 8, i + 1 == 7, i < 8, i >= 8, 1'b0, 16'h0};
        for (int j = 1; j <= 10; j++)
            tbl[9+j] = '{1'b0, 1'b1, 16'h0, (j <= 8) ? 8 - j : 0,
                         1'b0, j == 1, 1'b0, 1'b0, j > 8, 16'((j <= 8) ? j : 8)};

        // Reset / idle
        step(1, 0, 0, 0, 16'h0);
        step(1, 0, 1, 1, 16'hFFFF);
        cmp("reset_count", 32'(ifa.count), 0);
        cmp("reset_empty", 32'(ifa.empty), 1);
        cmp("reset_pulses", 32'({ifa.wr_ack, ifa.overflow, ifa.underflow}), 0);
`ifndef FIFO_FWFT_EN
        cmp("reset_data_out", 32'(ifa.data_out), 16'h0000);
`endif
        step(0, 0, 0, 0, 16'h0);

        for (int i = 0; i < 20; i++) begin
            step(0, 0, tbl[i].wr, tbl[i].rd, tbl[i].din);
            cmp($sformatf("tbl%0d_count", i), 32'(ifa.count), 32'(tbl[i].cnt));
            cmp($sformatf("tbl%0d_full", i), 32'(ifa.full), 32'(tbl[i].full));
            cmp($sformatf("tbl%0d_af", i), 32'(ifa.almostfull), 32'(tbl[i].af));
            cmp($sformatf("tbl%0d_pulses", i), 32'({ifa.wr_ack, ifa.overflow, ifa.underflow}),
                32'({tbl[i].ack, tbl[i].ov, tbl[i].un}));
`ifndef FIFO_FWFT_EN
            cmp($sformatf("tbl%0d_dout", i), 32'(ifa.data_out), 32'(tbl[i].dout));
`endif
        end

        // Full with simultaneous read+write
        step(1, 0, 0, 0, 16'h0);
        for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 16'(16'h11 + i));
        step(0, 0, 1, 1, 16'hBEEF);
        cmp("fullsim_ack", 32'(ifa.wr_ack), 1);
        cmp("fullsim_ovf", 32'(ifa.overflow), 0);
        cmp("fullsim_count", 32'(ifa.count), 8);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
        cmp("fullsim_beef_8th", 32'(ifa.data_out), 16'hBEEF);
`endif

        // Empty with simultaneous read+write
        step(0, 0, 1, 1, 16'h1234);
        cmp("emptysim_underflow", 32'(ifa.underflow), 1);
        cmp("emptysim_ack", 32'(ifa.wr_ack), 1);
        cmp("emptysim_count", 32'(ifa.count), 1);
`ifdef FIFO_FWFT_EN
        cmp("fwft_first_word", 32'(ifa.data_out), 16'h1234);
`endif
        step(0, 0, 0, 1, 16'h0);
`ifndef FIFO_FWFT_EN
        cmp("emptysim_read", 32'(ifa.data_out), 16'h1234);
`endif

        // Flush mid-stream, then rst and flush together
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 16'(16'h50 + i));
        step(0, 1, 1, 0, 16'h7777);
        cmp("flush_count", 32'(ifa.count), 0);
        cmp("flush_empty", 32'(ifa.empty), 1);
        cmp("flush_ack", 32'(ifa.wr_ack), 0);
        step(0, 0, 0, 1, 16'h0);
        cmp("flush_next_underflow", 32'(ifa.underflow), 1);
        step(1, 1, 1, 1, 16'h9999);
`ifndef FIFO_FWFT_EN
        cmp("rst_over_flush_dout", 32'(ifa.data_out), 16'h0000);
`endif
        cmp("rst_over_flush_count", 32'(ifa.count), 0);

        // Randomised traffic; the model checks both FIFOs every cycle.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 9) < 5, 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
- Next-generation synchronous FIFO: parametrised width/depth (any depth ≥ 2, not limited to powers of two).
- Adds occupancy count, parameter-set almost-full/almost-empty thresholds, a synchronous flush, and simultaneous read/write when full.
- Drop-in storage element between a single-clock producer and consumer; status flags feed the same scoreboard/assertion environment as the existing FIFO.

Parameters:
- FIFO_WIDTH, 16, data word width in bits.
- FIFO_DEPTH, 8, number of entries; legal range is 2..1024 and may be non-power-of-2.
- AF_LEVEL, FIFO_DEPTH-1, almostfull asserts when count ≥ AF_LEVEL and count < FIFO_DEPTH.
- AE_LEVEL, 1, almostempty asserts when count ≤ AE_LEVEL and count > 0.
- CNT_W, $clog2(FIFO_DEPTH+1), count width (derived; do not override).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- flush  input  1  synchronous clear of contents; keeps configuration.
- data_in  input  FIFO_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- data_out  output  FIFO_WIDTH  read data.
- count  output  CNT_W  current occupancy, 0..FIFO_DEPTH.
- full  output  1  count == FIFO_DEPTH.
- empty  output  1  count == 0.
- almostfull  output  1  see AF_LEVEL.
- almostempty  output  1  see AE_LEVEL.
- wr_ack  output  1  registered pulse: write accepted in previous cycle.
- overflow  output  1  registered pulse: write rejected in previous cycle.
- underflow  output  1  registered pulse: read rejected in previous cycle.

Behaviour:
- Reset (rst=1 at edge): wr_ptr=rd_ptr=0, count=0, data_out=0, wr_ack=overflow=underflow=0; empty=1, full=almostfull=almostempty=0. Memory contents are not cleared.
- rst has priority over flush; flush has priority over wr_en/rd_en.
- Flush: same as reset except data_out holds its value. Requests in the flush cycle are ignored, and no ack/overflow/underflow is generated for them.
- rd_acc = rd_en && !empty.
- wr_acc = wr_en && (!full || rd_acc): a write while full succeeds only when paired with an accepted read.
- Read while empty with a simultaneous write: the read is rejected (underflow=1 next cycle) and the write is accepted.
- Write: mem[wr_ptr] <= data_in. wr_ptr increments modulo FIFO_DEPTH (wraps FIFO_DEPTH-1 → 0 explicitly, no power-of-2 masking).
- Read (standard mode): data_out <= mem[rd_ptr], visible 1 cycle after rd_acc. rd_ptr increments modulo FIFO_DEPTH. data_out holds when there is no rd_acc.
- count next = count + wr_acc − rd_acc. Count is unchanged when both are accepted.
- Status flags are combinational decodes of the registered count, so they change the cycle after the causing operation.
- wr_ack next = wr_acc; overflow next = wr_en && !wr_acc; underflow next = rd_en && !rd_acc. Each is a single-cycle pulse per request cycle.
- Parameter checks at elaboration: AE_LEVEL < AF_LEVEL ≤ FIFO_DEPTH, otherwise $fatal.

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word-fall-through read mode.
- Defined:
  - data_out = mem[rd_ptr] combinationally; valid whenever empty=0.
  - rd_acc pops the word currently shown, and the next word appears the following cycle.
  - data_out is undefined (don't-care) when empty=1; the reset value does not apply.
  - Flush and threshold behaviour are unchanged.
- Undefined: registered 1-cycle read latency as described in Behaviour.

Test Plan:
- Reset/idle: rst=1 for 2 cycles → count=0, empty=1, data_out=16'h0000, all pulses 0.
- Fill/drain with wrap: write 0x0001..0x000A (10 writes, depth 8) →
  - wr_ack ×8, overflow on writes 9–10, full=1, almostfull 0→1 at count=7 then 0 at count=8;
  - 10 reads return 0x0001..0x0008 in order, underflow on reads 9–10;
  - pointers pass through 7→0.
- Full simultaneous: at count=8 assert wr_en+rd_en with 0xBEEF → wr_ack=1, overflow=0, count stays 8; 0xBEEF is read 8th after subsequent reads.
- Empty simultaneous: at count=0 assert wr_en+rd_en with 0x1234 → underflow=1, wr_ack=1, count=1, next read returns 0x1234.
- Flush mid-stream: at count=5, flush=1 with wr_en=1 → count=0, empty=1, wr_ack=0, next read underflows. With rst and flush both high, reset behaviour wins (data_out=0).
- Non-power-of-2: FIFO_DEPTH=6, AE_LEVEL=2, AF_LEVEL=4 → 20 random writes/reads match the scoreboard; almostempty at counts 1–2, almostfull at 4–5, full at 6. FIFO_FWFT_EN build shows the first word with no rd_en.
